vpi_chan_checker: RTL and testbench
===================================

// Module: vpi_chan_checker
// PURPOSE
// - Parametrised bank of NCHAN VPI-visible sig/rfr channel register pairs, generalising the fixed 6-instance arr.
// - Adds a per-channel check-mask scan FSM, a saturating error log and a run counter with a finish flag.
// - Used by VPI regression tops: the C side writes sig/rfr through the write port or VPI, then requests a check.
// PARAMETERS
// - NCHAN      6     number of channels (1..32)
// - WIDTH      8     storage width of each sig/rfr register; channel c compares LEN(c)=min(c+1,WIDTH) LSBs
// - STEP       2     count increment per clock
// - END_COUNT  1000  count value that sets finished
// - ERRW       8     err_count width, saturating
// PORTS
// - clk         in   1               clock; all logic on posedge
// - rst         in   1               synchronous reset, active-high
// - wr_en       in   1               write strobe for one channel register
// - wr_chan     in   $clog2(NCHAN)   channel index; values >= NCHAN are ignored
// - wr_sel      in   1               0 = sig, 1 = rfr
// - wr_data     in   WIDTH           write data; bits >= LEN(chan) are stored as 0
// - check_req   in   1               start a scan; sampled only in IDLE
// - check_mask  in   NCHAN           channels to compare, captured with check_req
// - check_busy  out  1               high in SCAN and DONE
// - check_done  out  1               one-cycle pulse at scan end
// - err_count   out  ERRW            total mismatches since reset, saturating
// - err_valid   out  1               sticky; high after the first mismatch
// - err_chan    out  $clog2(NCHAN)   channel of the first mismatch since reset
// - count       out  32              run counter, public_flat_rd
// - half_count  out  32              secondary counter, public_flat_rd
// - finished    out  1               sticky; high once count == END_COUNT
// BEHAVIOUR
// - Reset: every sig, rfr, count, half_count and err_count is 0; err_valid, err_chan, check_busy, check_done and finished are 0; FSM in IDLE.
// - Storage: sig[c] and rfr[c] are public_flat_rw, so VPI writes are legal at any time; the RTL write port takes effect on the next edge.
// - FSM states:
//   - IDLE: on check_req with check_mask != 0, latch the mask, set idx=0 and go to SCAN. A zero mask pulses check_done with no scan.
//   - SCAN: one channel per cycle, idx 0..NCHAN-1, unmasked channels included. If mask[idx] and sig[idx][LEN-1:0] != rfr[idx][LEN-1:0], it is a mismatch. Go to DONE after idx = NCHAN-1.
//   - DONE: check_done=1 for exactly one cycle, then IDLE.
// - Scan latency: check_req at cycle N gives check_done at cycle N+NCHAN+1. Zero mask: check_done at N+1.
// - Mismatch: err_count += 1 and saturates at 2^ERRW-1. On the first mismatch only, err_chan=idx and err_valid=1.
// - check_req while busy is ignored and not queued.
// - Write vs compare in the same cycle on the same channel: the compare uses the pre-write value.
// - Counters: while !finished, count += STEP each cycle; half_count += STEP when the pre-update count[1]==1.
//   - Both counters wrap modulo 2^32.
//   - When the next count equals END_COUNT, finished=1 and both counters freeze. The scan FSM keeps working.
//   - If END_COUNT is unreachable (e.g. odd END_COUNT with even STEP), finished never rises.
// - rst mid-scan: immediate return to IDLE, no check_done, all storage and error state cleared.
// CONFIGURATION
// - VPI_CHECK_VERBOSE_EN defined: each SCAN cycle with mask[idx]=1 issues $display("%m : chan %0d %x %x", idx, sig, rfr). A mismatch additionally issues $stop.
// - VPI_CHECK_VERBOSE_EN undefined: no display or $stop. Mismatches are reported only through err_*; all other logic is identical.
// TESTING
// - Reset, then idle 5 cycles -> count=10, half_count=4 (half_count increments on cycles 2 and 4), all err_* =0, check_busy=0.
// - NCHAN=6, WIDTH=8: write sig[2]=8'hFF, rfr[2]=8'h07 (LEN 3, stored 3'h7 both), mask=6'h04 -> check_done at N+7, err_count=0.
// - sig[5]=6'h15, rfr[5]=6'h2A, mask=6'h3F -> err_count=1, err_chan=5, err_valid=1. Repeat -> err_count=2, err_chan stays 5.
// - check_req held high through a scan -> exactly one check_done per NCHAN+2 cycles, never back-to-back.
// - Write rfr[0]=1 in the same cycle SCAN compares idx 0 with sig[0]=0, rfr[0]=0 -> no error; rescan -> err_count+1.
// - Run to count==1000 -> finished=1 and counters frozen. Assert rst mid-scan -> no check_done, all outputs 0 the next cycle.

Source files
------------

// File: rtl/vpi_chan_checker.sv
// Bank of NCHAN sig/rfr channel register pairs with a masked compare scan, error log and run counter.
// Optional VPI_CHECK_VERBOSE_EN: print each compared channel and $stop on a mismatch.
module vpi_chan_checker #(
    parameter int unsigned NCHAN     = 6,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STEP      = 2,
    parameter int unsigned END_COUNT = 1000,
    parameter int unsigned ERRW      = 8,
    localparam int unsigned CW       = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CW-1:0]    wr_chan,
    input  logic             wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             check_req,
    input  logic [NCHAN-1:0] check_mask,
    output logic             check_busy,
    output logic             check_done,
    output logic [ERRW-1:0]  err_count,
    output logic             err_valid,
    output logic [CW-1:0]    err_chan,
    output logic [31:0]      count,
    output logic [31:0]      half_count,
    output logic             finished
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [NCHAN-1:0] mask_q, mask_d;

    logic [WIDTH-1:0] sig_q [NCHAN];
    logic [WIDTH-1:0] rfr_q [NCHAN];
    logic [NCHAN-1:0] mis_vec;
    logic             scan_hit;
    logic [31:0]      count_nxt;

    // Channel c only keeps min(c+1, WIDTH) LSBs.
    function automatic logic [WIDTH-1:0] len_mask(input int unsigned c);
        logic [WIDTH-1:0] m;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            m[i] = (i <= c);
        end
        return m;
    endfunction

    // Channel storage; out-of-range channel indices match no channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < NCHAN; c++) begin
                sig_q[c] <= '0;
                rfr_q[c] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned c = 0; c < NCHAN; c++) begin
                if (wr_chan == CW'(c)) begin
                    if (wr_sel) rfr_q[c] <= wr_data & len_mask(c);
                    else        sig_q[c] <= wr_data & len_mask(c);
                end
            end
        end
    end

    always_comb begin
        mis_vec = '0;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            mis_vec[c] = |((sig_q[c] ^ rfr_q[c]) & len_mask(c));
        end
    end

    assign scan_hit = (state_q == SCAN) && mask_q[idx_q] && mis_vec[idx_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            mask_q     <= '0;
            check_busy <= 1'b0;
            check_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mask_q     <= mask_d;
            check_busy <= (state_d != IDLE);
            check_done <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (check_req) begin
                    if (check_mask != '0) begin
                        mask_d  = check_mask;
                        idx_d   = '0;
                        state_d = SCAN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SCAN: begin
                if (idx_q == CW'(NCHAN - 1)) state_d = DONE;
                else                         idx_d   = idx_q + CW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Saturating error count; channel of the first mismatch is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
            err_valid <= 1'b0;
            err_chan  <= '0;
        end else if (scan_hit) begin
            if (err_count != {ERRW{1'b1}}) err_count <= err_count + ERRW'(1);
            if (!err_valid) begin
                err_valid <= 1'b1;
                err_chan  <= idx_q;
            end
        end
    end

    assign count_nxt = count + 32'(STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            half_count <= '0;
            finished   <= 1'b0;
        end else if (!finished) begin
            count <= count_nxt;
            if (count[1]) half_count <= half_count + 32'(STEP);
            if (count_nxt == 32'(END_COUNT)) finished <= 1'b1;
        end
    end

`ifdef VPI_CHECK_VERBOSE_EN
    always_ff @(posedge clk) begin
        if (!rst && (state_q == SCAN) && mask_q[idx_q]) begin
            $display("%m : chan %0d %x %x", idx_q, sig_q[idx_q], rfr_q[idx_q]);
            if (mis_vec[idx_q]) $stop;
        end
    end
`else
    // Mismatches are reported only through the err_* outputs.
`endif

endmodule

// File: tb/tb_vpi_chan_checker.sv
// Randomised self-checking bench for vpi_chan_checker against a channel/error/counter reference model.
module tb_vpi_chan_checker;

    localparam int NCHAN = 6;
    localparam int WIDTH = 8;
    localparam int STEP = 2;
    localparam int END_COUNT = 1000;
    localparam int ERRW = 8;
    localparam int CW = 3;
    localparam int ERR_MAX = (1 << ERRW) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [CW-1:0]    wr_chan = '0;
    logic             wr_sel = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             check_req = 1'b0;
    logic [NCHAN-1:0] check_mask = '0;
    logic             check_busy, check_done, err_valid, finished;
    logic [ERRW-1:0]  err_count;
    logic [CW-1:0]    err_chan;
    logic [31:0]      count, half_count;

    int checks = 0;
    int errors = 0;
    int ncyc = 0;

    // Reference model state
    int m_sig [NCHAN];
    int m_rfr [NCHAN];
    int m_err = 0;
    bit m_valid = 1'b0;
    int m_chan = 0;

    vpi_chan_checker #(
        .NCHAN(NCHAN), .WIDTH(WIDTH), .STEP(STEP), .END_COUNT(END_COUNT), .ERRW(ERRW)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_chan(wr_chan), .wr_sel(wr_sel), .wr_data(wr_data),
        .check_req(check_req), .check_mask(check_mask),
        .check_busy(check_busy), .check_done(check_done),
        .err_count(err_count), .err_valid(err_valid), .err_chan(err_chan),
        .count(count), .half_count(half_count), .finished(finished)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL timeout global time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lenmask(input int c);
        int l;
        l = (c + 1 < WIDTH) ? c + 1 : WIDTH;
        return (1 << l) - 1;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCHAN; c++) begin
            m_sig[c] = 0;
            m_rfr[c] = 0;
        end
        m_err = 0;
        m_valid = 1'b0;
        m_chan = 0;
    endfunction

    function automatic void model_write(input int chan, input bit sel, input int data);
        if (chan < NCHAN) begin
            if (sel) m_rfr[chan] = data & lenmask(chan);
            else     m_sig[chan] = data & lenmask(chan);
        end
    endfunction

    function automatic void model_scan(input logic [NCHAN-1:0] mask);
        for (int c = 0; c < NCHAN; c++) begin
            if (mask[c] && (((m_sig[c] ^ m_rfr[c]) & lenmask(c)) != 0)) begin
                if (!m_valid) begin
                    m_valid = 1'b1;
                    m_chan = c;
                end
                if (m_err < ERR_MAX) m_err++;
            end
        end
    endfunction

    // Counters after t unreset cycles: STEP per cycle until END_COUNT is reached.
    task automatic model_counters(input int t, output logic [31:0] c, output logic [31:0] h,
                                  output logic f);
        int  lim, steps;
        bit  reach;
        reach = (END_COUNT % STEP) == 0;
        lim = END_COUNT / STEP;
        steps = (reach && t >= lim) ? lim : t;
        c = 32'(STEP * steps);
        h = 0;
        for (int k = 0; k < steps; k++) begin
            if ((((STEP * k) >> 1) & 1) == 1) h = h + 32'(STEP);
        end
        f = reach && (t >= lim);
    endtask

    task automatic wr(input int chan, input bit sel, input int data);
        wr_en = 1'b1;
        wr_chan = CW'(chan);
        wr_sel = sel;
        wr_data = WIDTH'(data);
        tick();
        wr_en = 1'b0;
        model_write(chan, sel, data);
    endtask

    // Runs one scan, checks latency and the error log against the model.
    task automatic run_scan(input logic [NCHAN-1:0] mask, input string tag);
        int lat, exp_lat;
        check_mask = mask;
        check_req = 1'b1;
        tick();
        check_req = 1'b0;
        lat = 1;
        while (!check_done && lat < NCHAN + 6) begin
            tick();
            lat++;
        end
        exp_lat = (mask != 0) ? NCHAN + 1 : 1;
        model_scan(mask);
        checks++;
        if (!check_done || lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency got %0d done=%b exp %0d", tag, lat, check_done, exp_lat);
        end
        checks++;
        if (err_count !== ERRW'(m_err)) begin
            errors++;
            $display("FAIL %s err_count got %0d exp %0d", tag, err_count, m_err);
        end
        checks++;
        if (err_valid !== m_valid) begin
            errors++;
            $display("FAIL %s err_valid got %b exp %b", tag, err_valid, m_valid);
        end
        if (m_valid) begin
            checks++;
            if (err_chan !== CW'(m_chan)) begin
                errors++;
                $display("FAIL %s err_chan got %0d exp %0d", tag, err_chan, m_chan);
            end
        end
        tick();
        checks++;
        if (check_done !== 1'b0 || check_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s post_done got done=%b busy=%b exp 0 0", tag, check_done, check_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        model_reset();
        checks++;
        if ({count, half_count, err_count, err_valid, err_chan, check_busy, check_done, finished} !== '0) begin
            errors++;
            $display("FAIL reset_state got count=%0d half=%0d err=%0d valid=%b chan=%0d busy=%b done=%b fin=%b exp all 0",
                     count, half_count, err_count, err_valid, err_chan, check_busy, check_done, finished);
        end
        rst = 1'b0;
        repeat (5) tick();
        checks++;
        if (count !== 32'd10) begin
            errors++;
            $display("FAIL idle5_count got %0d exp 10", count);
        end
        checks++;
        if (half_count !== 32'd4) begin
            errors++;
            $display("FAIL idle5_half got %0d exp 4", half_count);
        end
        checks++;
        if ({err_count, err_valid, err_chan, check_busy, finished} !== '0) begin
            errors++;
            $display("FAIL idle5_flags got err=%0d valid=%b chan=%0d busy=%b fin=%b exp 0",
                     err_count, err_valid, err_chan, check_busy, finished);
        end
    endtask

    task automatic test_len_mask();
        wr(2, 1'b0, 8'hFF);
        wr(2, 1'b1, 8'h07);
        run_scan(6'h04, "len_mask");
    endtask

    task automatic test_mismatch();
        wr(5, 1'b0, 8'h15);
        wr(5, 1'b1, 8'h2A);
        run_scan(6'h3F, "mismatch1");
        run_scan(6'h3F, "mismatch2");
    endtask

    task automatic test_back_to_back();
        int np = NCHAN + 2;
        int pulses = 0;
        bit exp_done;
        check_mask = 6'h04;
        check_req = 1'b1;
        for (int i = 1; i <= 3 * np; i++) begin
            tick();
            exp_done = (i % np) == (np - 1);
            if (check_done) pulses++;
            checks++;
            if (check_done !== exp_done) begin
                errors++;
                $display("FAIL held_req tick %0d done got %b exp %b", i, check_done, exp_done);
            end
        end
        check_req = 1'b0;
        for (int k = 0; k < 3; k++) model_scan(6'h04);
        tick();
        checks++;
        if (pulses != 3 || check_busy !== 1'b0) begin
            errors++;
            $display("FAIL held_req pulses got %0d busy=%b exp 3 0", pulses, check_busy);
        end
    endtask

    task automatic test_same_cycle_write();
        int lat;
        check_mask = 6'h01;
        check_req = 1'b1;
        tick();
        check_req = 1'b0;
        wr_en = 1'b1;
        wr_chan = 3'd0;
        wr_sel = 1'b1;
        wr_data = 8'h01;
        tick();
        wr_en = 1'b0;
        lat = 2;
        while (!check_done && lat < NCHAN + 6) begin
            tick();
            lat++;
        end
        model_scan(6'h01);
        model_write(0, 1'b1, 1);
        checks++;
        if (!check_done || lat != NCHAN + 1) begin
            errors++;
            $display("FAIL same_cycle latency got %0d exp %0d", lat, NCHAN + 1);
        end
        checks++;
        if (err_count !== ERRW'(m_err)) begin
            errors++;
            $display("FAIL same_cycle err_count got %0d exp %0d", err_count, m_err);
        end
        tick();
        run_scan(6'h01, "same_cycle_rescan");
    endtask

    task automatic test_random();
        logic [NCHAN-1:0] mask;
        for (int it = 0; it < 20; it++) begin
            for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
                wr(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            end
            mask = ($urandom_range(0, 4) == 0) ? '0 : NCHAN'($urandom);
            run_scan(mask, "random");
        end
    endtask

    task automatic test_finish();
        logic [31:0] ec, eh;
        logic        ef;
        int          guard = 0;
        while (ncyc < END_COUNT / STEP - 1 && guard < 5000) begin
            tick();
            guard++;
        end
        if (ncyc == END_COUNT / STEP - 1) begin
            checks++;
            if (finished !== 1'b0 || count !== 32'(END_COUNT - STEP)) begin
                errors++;
                $display("FAIL pre_finish got count=%0d fin=%b exp %0d 0", count, finished, END_COUNT - STEP);
            end
        end
        while (ncyc < END_COUNT / STEP + 12 && guard < 5000) begin
            tick();
            guard++;
        end
        model_counters(ncyc, ec, eh, ef);
        checks++;
        if (count !== 32'd1000 || count !== ec) begin
            errors++;
            $display("FAIL finish_count got %0d exp %0d", count, ec);
        end
        checks++;
        if (half_count !== eh) begin
            errors++;
            $display("FAIL finish_half got %0d exp %0d", half_count, eh);
        end
        checks++;
        if (finished !== 1'b1 || finished !== ef) begin
            errors++;
            $display("FAIL finish_flag got %b exp %b", finished, ef);
        end
    endtask

    task automatic test_saturate();
        for (int c = 0; c < NCHAN; c++) begin
            wr(c, 1'b0, 8'hFF);
            wr(c, 1'b1, 8'h00);
        end
        for (int k = 0; k < 45; k++) run_scan(6'h3F, "saturate");
        checks++;
        if (err_count !== ERRW'(ERR_MAX)) begin
            errors++;
            $display("FAIL saturate_final got %0d exp %0d", err_count, ERR_MAX);
        end
    endtask

    task automatic test_reset_mid_scan();
        int pulses = 0;
        check_mask = 6'h3F;
        check_req = 1'b1;
        tick();
        check_req = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        model_reset();
        checks++;
        if ({count, half_count, err_count, err_valid, err_chan, check_busy, check_done, finished} !== '0) begin
            errors++;
            $display("FAIL mid_reset got count=%0d half=%0d err=%0d valid=%b chan=%0d busy=%b done=%b fin=%b exp all 0",
                     count, half_count, err_count, err_valid, err_chan, check_busy, check_done, finished);
        end
        rst = 1'b0;
        for (int i = 0; i < NCHAN + 3; i++) begin
            tick();
            if (check_done || check_busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL mid_reset_no_done got %0d busy/done cycles exp 0", pulses);
        end
        run_scan(6'h3F, "post_reset_scan");
    endtask

    initial begin
        test_reset();
        test_len_mask();
        test_mismatch();
        test_back_to_back();
        test_same_cycle_write();
        test_random();
        test_finish();
        test_saturate();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
